// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready handshake bundle for the sequential inverse SubBytes engine.
// master = upstream/downstream driver, slave = the engine.
interface inv_sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES inverse SubBytes, LANES bytes per cycle, MSB byte group first.
// INV_SUB_BYTES_FWD_MODE_EN adds a per-block fwd select for the forward S-box.
module inv_sub_bytes_lane (
`ifdef INV_SUB_BYTES_FWD_MODE_EN
  input  logic       fwd,
`endif
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

`ifdef INV_SUB_BYTES_FWD_MODE_EN
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // One inverter shared by both directions; affine steps swap sides
  logic [7:0] g;
  assign g    = gf_inv(fwd ? din : inv_affine(din));
  assign dout = fwd ? affine(g) : g;
`else
  assign dout = gf_inv(inv_affine(din));
`endif
endmodule

module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef INV_SUB_BYTES_FWD_MODE_EN
  input  logic fwd,
`endif
  inv_sub_bytes_seq_if.slave bus,
  output logic busy
);
  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [N-1:0][LANES-1:0][7:0]    data_q;
  logic [CW-1:0]                   cnt_q;
  logic [CW-1:0]                   grp_idx;
  logic [LANES-1:0][7:0]           grp_in, grp_out;
  logic                            accept, last;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
  logic                            fwd_q;
`endif

  // Group 0 (bytes 0..LANES-1) lives in the top slice of the register
  assign grp_idx      = LAST - cnt_q;
  assign grp_in       = data_q[grp_idx];
  assign last         = (cnt_q == LAST);
  assign bus.out_data = data_q;

  inv_sub_bytes_lane u_lane [LANES-1:0] (
`ifdef INV_SUB_BYTES_FWD_MODE_EN
    .fwd  (fwd_q),
`endif
    .din  (grp_in),
    .dout (grp_out)
  );

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          accept  = bus.in_valid;
          state_d = bus.in_valid ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
      fwd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= bus.in_data;
        cnt_q  <= '0;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
        fwd_q  <= fwd;
`endif
      end else if (state_q == RUN) begin
        data_q[grp_idx] <= grp_out;
        if (!last) cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: five DUTs (LANES=1,2,4,8,16) against a table model.
// Exercises the fwd path too when INV_SUB_BYTES_FWD_MODE_EN is defined.
module tb_inv_sub_bytes_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]        iv, ordy;
  logic [4:0][127:0] idat;
  wire  [4:0]        irdy, ov, bsy;
  wire  [4:0][127:0] odat;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
  logic fwd_s;
`endif

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_sub_bytes_seq_if bi ();
    assign bi.in_valid  = iv[g];
    assign bi.in_data   = idat[g];
    assign bi.out_ready = ordy[g];
    assign irdy[g]      = bi.in_ready;
    assign ov[g]        = bi.out_valid;
    assign odat[g]      = bi.out_data;
    inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk  (clk),
      .rst  (rst),
`ifdef INV_SUB_BYTES_FWD_MODE_EN
      .fwd  (fwd_s),
`endif
      .bus  (bi.slave),
      .busy (bsy[g])
    );
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  // Carry-less product reduced by long division with x^8+x^4+x^3+x+1
  function automatic int pmul_mod(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (a << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (32'h11b << (k - 8));
    return p & 255;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      logic [7:0] b, s;
      logic [7:0] c = 8'h63;
      if (x != 0) for (int y = 1; y < 256; y++) if (pmul_mod(x, y) == 1) inv = y;
      b = inv[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
      isbox_t[s] = x[7:0];
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] din, input logic f);
    logic [127:0] r;
    for (int b = 0; b < 16; b++)
      r[127-8*b -: 8] = f ? sbox_t[din[127-8*b -: 8]] : isbox_t[din[127-8*b -: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d, input logic [127:0] din, input logic f);
`ifdef INV_SUB_BYTES_FWD_MODE_EN
    fwd_s = f;
`endif
    idat[d] = din;
    iv[d]   = 1'b1;
    #1;
    chk1("accept_ready", irdy[d], 1'b1);
    step();
    iv[d] = 1'b0;
  endtask

  // junk: keep in_valid high with other data (and flipped fwd) during RUN
  task automatic wait_done(input int d, input logic [127:0] exp, input logic f, input logic junk);
    int lat = 0;
    int n = 16 >> d;
    if (junk) begin
      iv[d]   = 1'b1;
      idat[d] = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_SUB_BYTES_FWD_MODE_EN
      fwd_s = ~f;
`endif
    end
    while (!ov[d] && lat < 40) begin
      chk1("run_in_ready", irdy[d], 1'b0);
      chk1("run_busy", bsy[d], 1'b1);
      step();
      lat++;
    end
    iv[d] = 1'b0;
    chk("latency", 128'(lat), 128'(n));
    chk1("out_valid", ov[d], 1'b1);
    chk("result", odat[d], exp);
  endtask

  task automatic release_out(input int d);
    ordy[d] = 1'b1;
    #1;
    chk1("done_in_ready", irdy[d], 1'b1);
    step();
    ordy[d] = 1'b0;
    chk1("idle_valid", ov[d], 1'b0);
    chk1("idle_ready", irdy[d], 1'b1);
    chk1("idle_busy", bsy[d], 1'b0);
  endtask

  task automatic run_block(input int d, input logic [127:0] din, input logic f,
                           input logic junk, output logic [127:0] res);
    logic [127:0] exp = ref_block(din, f);
    start(d, din, f);
    wait_done(d, exp, f, junk);
    res = odat[d];
    release_out(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] res, a, b, c, ea, eb, ec;
    logic f;
    build_tables();
    rst = 1'b1; iv = '0; ordy = '0; idat = '0;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
    fwd_s = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    #1;
    for (int d = 0; d < 5; d++) begin
      chk1("rst_out_valid", ov[d], 1'b0);
      chk("rst_out_data", odat[d], 128'h0);
      chk1("rst_busy", bsy[d], 1'b0);
      chk1("rst_in_ready", irdy[d], 1'b1);
    end

    // All 0x63 maps to zero; junk in_valid during RUN must be ignored
    run_block(2, {16{8'h63}}, 1'b0, 1'b1, res);
    chk("all63", res, 128'h0);

    // Known bytes on every lane count
    for (int d = 0; d < 5; d++) begin
      run_block(d, 128'h637C00FF_16000000_00000000_00000000, 1'b0, 1'b0, res);
      chk("known", res, 128'h0001527D_FF525252_52525252_52525252);
    end

    // Random blocks
    for (int d = 0; d < 5; d++)
      for (int k = 0; k < 3; k++) begin
        f = 1'b0;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
        f = 1'($urandom_range(0, 1));
`endif
        run_block(d, {$urandom, $urandom, $urandom, $urandom}, f, k == 1, res);
      end

    // Backpressure then back-to-back accept from DONE
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    ea = ref_block(a, 1'b0);
    eb = ref_block(b, 1'b0);
    start(2, a, 1'b0);
    wait_done(2, ea, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("bp_valid", ov[2], 1'b1);
      chk("bp_data", odat[2], ea);
    end
    ordy[2] = 1'b1; idat[2] = b; iv[2] = 1'b1;
    #1;
    chk1("b2b_in_ready", irdy[2], 1'b1);
    step();
    iv[2] = 1'b0; ordy[2] = 1'b0;
    chk1("b2b_valid_drop", ov[2], 1'b0);
    chk1("b2b_busy", bsy[2], 1'b1);
    wait_done(2, eb, 1'b0, 1'b0);
    release_out(2);

    // Reset with cnt=2: partial register shows only the top two groups done
    c = {$urandom, $urandom, $urandom, $urandom};
    ec = ref_block(c, 1'b0);
    start(2, c, 1'b0);
    step(); step();
    chk("partial", odat[2], {ec[127:64], c[63:0]});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("mrst_valid", ov[2], 1'b0);
    chk("mrst_data", odat[2], 128'h0);
    chk1("mrst_busy", bsy[2], 1'b0);
    chk1("mrst_ready", irdy[2], 1'b1);
    run_block(2, c, 1'b0, 1'b0, res);

`ifdef INV_SUB_BYTES_FWD_MODE_EN
    run_block(2, 128'h0, 1'b1, 1'b1, res);
    chk("fwd_zero", res, {16{8'h63}});
    run_block(2, res, 1'b0, 1'b1, res);
    chk("fwd_roundtrip", res, 128'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
